// File: rtl/an_ord_receiver_if.sv
// an_ord_receiver_if: decoded 8b/10b symbol stream feeding the AN ordered-set receiver
interface an_ord_receiver_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_is_k;
  logic       rx_code_err;
  modport master (output rx_valid, rx_data, rx_is_k, rx_code_err);
  modport slave  (input  rx_valid, rx_data, rx_is_k, rx_code_err);
endinterface

// File: rtl/an_ord_receiver.sv
// an_ord_receiver: parses /C1/,/C2/,/I1/,/I2/ sets into config word and AN match qualifiers.
// Defining AN_RX_ERRCNT_EN builds the saturating error counter; otherwise err_count is tied to 0.
module an_ord_receiver #(
  parameter int MATCH_COUNT = 3,
  parameter int IDLE_COUNT  = 3,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 sgmii_clk_in,
  input  logic                 reset_n,
  an_ord_receiver_if.slave     rx,
  output logic [15:0]          cfg_word,
  output logic                 cfg_valid,
  output logic                 ability_match,
  output logic                 ack_match,
  output logic                 idle_match,
  output logic                 link_up,
  output logic                 duplex,
  output logic [1:0]           speed,
  output logic [ERR_CNT_W-1:0] err_count
);
  typedef enum logic [1:0] {HUNT, COMMA, CFG_LO, CFG_HI} state_t;
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int IW = $clog2(IDLE_COUNT + 1);
  localparam logic [MW-1:0] MC = MW'(MATCH_COUNT);
  localparam logic [IW-1:0] IC = IW'(IDLE_COUNT);
  state_t state_q, state_d;
  logic [7:0] lo_q, lo_d;
  logic [15:0] cfg_word_q, cfg_word_d;
  logic [MW-1:0] match_cnt_q, match_cnt_d, ack_cnt_q, ack_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic cfg_valid_q, cfg_valid_d, ability_q, ability_d, ack_q, ack_d, idle_q, idle_d;
  logic link_up_q, link_up_d, duplex_q, duplex_d;
  logic [1:0] speed_q, speed_d;
  logic k28_5, is_c, is_i, cfg_ev, idle_ev, same;
  logic [15:0] word_new;
  assign k28_5    = rx.rx_is_k && rx.rx_data == 8'hBC;
  assign is_c     = !rx.rx_is_k && (rx.rx_data == 8'hB5 || rx.rx_data == 8'h42);
  assign is_i     = !rx.rx_is_k && (rx.rx_data == 8'hC5 || rx.rx_data == 8'h50);
  assign word_new = {rx.rx_data, lo_q};
  // a zero match count means no reference word, so the next word always restarts at 1
  assign same = match_cnt_q != '0 && (word_new & 16'hBFFF) == (cfg_word_q & 16'hBFFF);
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    cfg_word_d  = cfg_word_q;
    match_cnt_d = match_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    link_up_d   = link_up_q;
    duplex_d    = duplex_q;
    speed_d     = speed_q;
    cfg_valid_d = 1'b0;
    cfg_ev      = 1'b0;
    idle_ev     = 1'b0;
    if (rx.rx_valid && rx.rx_code_err) begin
      state_d     = HUNT;
      match_cnt_d = '0;
      ack_cnt_d   = '0;
      idle_cnt_d  = '0;
    end else if (rx.rx_valid) begin
      case (state_q)
        HUNT:   state_d = k28_5 ? COMMA : HUNT;
        COMMA: begin
          state_d = is_c ? CFG_LO : k28_5 ? COMMA : HUNT;
          idle_ev = is_i;
        end
        CFG_LO: begin
          state_d = k28_5 ? COMMA : rx.rx_is_k ? HUNT : CFG_HI;
          lo_d    = rx.rx_is_k ? lo_q : rx.rx_data;
        end
        CFG_HI: begin
          state_d = k28_5 ? COMMA : HUNT;
          cfg_ev  = !rx.rx_is_k;
        end
      endcase
    end
    if (cfg_ev) begin
      cfg_word_d  = word_new;
      cfg_valid_d = 1'b1;
      idle_cnt_d  = '0;
      match_cnt_d = !same ? MW'(1) : match_cnt_q == MC ? MC : match_cnt_q + 1'b1;
      ack_cnt_d   = !word_new[14] ? '0 : !same ? MW'(1) : ack_cnt_q == MC ? MC : ack_cnt_q + 1'b1;
    end
    if (idle_ev) begin
      idle_cnt_d  = idle_cnt_q == IC ? IC : idle_cnt_q + 1'b1;
      match_cnt_d = '0;
      ack_cnt_d   = '0;
    end
    ability_d = match_cnt_d == MC;
    ack_d     = ability_d && ack_cnt_d == MC;
    idle_d    = idle_cnt_d == IC;
    if (cfg_ev && ability_d) begin
      link_up_d = word_new[15];
      duplex_d  = word_new[12];
      speed_d   = word_new[11:10];
    end
  end
  always_ff @(posedge sgmii_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      lo_q        <= '0;
      cfg_word_q  <= '0;
      match_cnt_q <= '0;
      ack_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      cfg_valid_q <= 1'b0;
      ability_q   <= 1'b0;
      ack_q       <= 1'b0;
      idle_q      <= 1'b0;
      link_up_q   <= 1'b0;
      duplex_q    <= 1'b0;
      speed_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      cfg_word_q  <= cfg_word_d;
      match_cnt_q <= match_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      cfg_valid_q <= cfg_valid_d;
      ability_q   <= ability_d;
      ack_q       <= ack_d;
      idle_q      <= idle_d;
      link_up_q   <= link_up_d;
      duplex_q    <= duplex_d;
      speed_q     <= speed_d;
    end
  end
  assign cfg_word      = cfg_word_q;
  assign cfg_valid     = cfg_valid_q;
  assign ability_match = ability_q;
  assign ack_match     = ack_q;
  assign idle_match    = idle_q;
  assign link_up       = link_up_q;
  assign duplex        = duplex_q;
  assign speed         = speed_q;
`ifdef AN_RX_ERRCNT_EN
  logic err_ev;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  assign err_ev = rx.rx_valid && (rx.rx_code_err ||
                  (state_q == COMMA && !is_c && !is_i) ||
                  ((state_q == CFG_LO || state_q == CFG_HI) && rx.rx_is_k));
  always_comb err_d = (err_ev && err_q != '1) ? err_q + 1'b1 : err_q;
  always_ff @(posedge sgmii_clk_in or negedge reset_n) begin
    if (!reset_n) err_q <= '0;
    else err_q <= err_d;
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif
endmodule
